lifo_stack: RTL and testbench

Parametrised LIFO stack with status flags, sticky error reporting and push/pop-replace. Successor to the basic push/pop stack: depth is configurable, the top entry is continuously visible, and overflow/underflow are detected and latched instead of silently corrupting the pointer. It is used wherever a block needs return-address or operand storage, such as sequencers and expression evaluators.

---
 rtl/lifo_stack.sv | 127 ++++++++++++
 tb/tb_lifo_stack.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO stack with registered top-of-stack, status
// flags, sticky overflow/underflow errors and push+pop top replacement.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   push         push data_in (with pop: replace top)
//   pop          drop top entry (with push: replace top)
//   clear_err    clear sticky error flags (a new error the same edge wins)
//   data_in      word to push / replace with
//   data_out     registered top-of-stack, 0 when empty
//   count        number of valid entries, 0..DEPTH
//   empty        count == 0
//   full         count == DEPTH
//   almost_full  count >= AFULL
//   overflow     sticky: push refused because the stack was full
//   underflow    sticky: pop refused because the stack was empty
module lifo_stack #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned SIZE  = 2,
    parameter int unsigned AFULL = (2 ** SIZE) - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              clear_err,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic [SIZE:0]     count,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned DEPTH = 2 ** SIZE;
    localparam int unsigned CW    = SIZE + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [SIZE:0]    count_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;
    logic             wr_en;
    logic [SIZE-1:0]  wr_idx;

    // Next-state decode of the push/pop pair; the top is always data_out.
    always_comb begin
        count_nxt = count;
        data_nxt  = data_out;
        ovf_nxt   = overflow & ~clear_err;
        unf_nxt   = underflow & ~clear_err;
        wr_en     = 1'b0;
        wr_idx    = '0;

        unique case ({push, pop})
            2'b10: begin
                if (!full) begin
                    wr_en     = 1'b1;
                    wr_idx    = SIZE'(count);
                    count_nxt = count + CW'(1);
                    data_nxt  = data_in;
                end else begin
                    ovf_nxt = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    count_nxt = count - CW'(1);
                    // New top lives two below the old count; none left -> 0.
                    if (count >= CW'(2)) begin
                        data_nxt = mem[SIZE'(count - CW'(2))];
                    end else begin
                        data_nxt = '0;
                    end
                end else begin
                    unf_nxt = 1'b1;
                end
            end
            2'b11: begin
                // Replace the top; on an empty stack this is a plain push.
                wr_en    = 1'b1;
                data_nxt = data_in;
                if (empty) begin
                    wr_idx    = '0;
                    count_nxt = CW'(1);
                end else begin
                    wr_idx = SIZE'(count - CW'(1));
                end
            end
            default: begin
            end
        endcase
    end

    // Storage array, not reset; writes suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem[wr_idx] <= data_in;
        end
    end

    // Pointer, top-of-stack, status and error registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count       <= '0;
            data_out    <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            count       <= count_nxt;
            data_out    <= data_nxt;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == CW'(DEPTH));
            almost_full <= (count_nxt >= CW'(AFULL));
            overflow    <= ovf_nxt;
            underflow   <= unf_nxt;
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed bench for lifo_stack (WIDTH=18, SIZE=2) with a
// queue-based reference stack checked every cycle plus literal expectations.
module tb_lifo_stack;

    localparam int unsigned WIDTH = 18;
    localparam int unsigned SIZE  = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AFULL = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic              clear_err = 1'b0;
    logic [WIDTH-1:0]  data_in = '0;
    logic [WIDTH-1:0]  data_out;
    logic [SIZE:0]     count;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              overflow;
    logic              underflow;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: a queue whose back is the top of stack.
    logic [WIDTH-1:0] stk[$];
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;
    bit               valid = 1'b0;

    lifo_stack #(.WIDTH(WIDTH), .SIZE(SIZE), .AFULL(AFULL)) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .clear_err   (clear_err),
        .data_in     (data_in),
        .data_out    (data_out),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic p, input logic q, input logic c,
                                input logic [WIDTH-1:0] d, input logic r);
        bit new_ovf;
        bit new_unf;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        if (!r) begin
            stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            valid = 1'b1;
            return;
        end
        if (p && q) begin
            if (stk.size() == 0) stk.push_back(d);
            else stk[stk.size() - 1] = d;
        end else if (p) begin
            if (stk.size() < DEPTH) stk.push_back(d);
            else new_ovf = 1'b1;
        end else if (q) begin
            if (stk.size() > 0) void'(stk.pop_back());
            else new_unf = 1'b1;
        end
        m_ovf = new_ovf ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = new_unf ? 1'b1 : (c ? 1'b0 : m_unf);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model.
    task automatic step(input logic p, input logic q, input logic c,
                        input logic [WIDTH-1:0] d, input logic r);
        push = p; pop = q; clear_err = c; data_in = d; reset = r;
        @(posedge clk);
        model_update(p, q, c, d, r);
        @(negedge clk);
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d);
        step(1'b1, 1'b0, 1'b0, d, 1'b1);
    endtask

    task automatic do_pop();
        step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    endtask

    // Per-cycle comparison of every output against the reference model.
    always @(negedge clk) begin
        if (valid) begin
            logic [WIDTH-1:0] top;
            int sz;
            sz  = stk.size();
            top = (sz > 0) ? stk[sz - 1] : '0;
            chk("model_data_out",    32'(data_out),    32'(top));
            chk("model_count",       32'(count),       32'(sz));
            chk("model_empty",       32'(empty),       32'(sz == 0));
            chk("model_full",        32'(full),        32'(sz == DEPTH));
            chk("model_almost_full", 32'(almost_full), 32'(sz >= AFULL));
            chk("model_overflow",    32'(overflow),    32'(m_ovf));
            chk("model_underflow",   32'(underflow),   32'(m_unf));
        end
    end

    initial begin
        logic [WIDTH-1:0] fill [4];
        fill[0] = 18'h15555; fill[1] = 18'h2AAAA; fill[2] = 18'h04444; fill[3] = 18'h3BBBB;

        // Reset held for two edges, then idle.
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_errs", 32'({overflow, underflow}), 32'd0);

        // Fill then overflow.
        for (int i = 0; i < 4; i++) begin
            do_push(fill[i]);
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_data", 32'(data_out), 32'(fill[i]));
        end
        chk("fill_full", 32'(full), 32'd1);
        do_push(18'h12345);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_data", 32'(data_out), 32'h3BBBB);
        chk("ovf_flag", 32'(overflow), 32'd1);

        // Drain then underflow.
        do_pop();
        chk("drain1", 32'(data_out), 32'h04444);
        chk("drain1_af", 32'(almost_full), 32'd1);
        do_pop();
        chk("drain2", 32'(data_out), 32'h2AAAA);
        do_pop();
        chk("drain3", 32'(data_out), 32'h15555);
        do_pop();
        chk("drain4", 32'(data_out), 32'h0);
        chk("drain4_empty", 32'(empty), 32'd1);
        do_pop();
        chk("unf_count", 32'(count), 32'd0);
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_ovf_kept", 32'(overflow), 32'd1);

        // Replace.
        do_push(18'h00001);
        do_push(18'h00002);
        step(1'b1, 1'b1, 1'b0, 18'h00003, 1'b1);
        chk("repl_count", 32'(count), 32'd2);
        chk("repl_data", 32'(data_out), 32'h00003);
        do_pop();
        chk("repl_pop", 32'(data_out), 32'h00001);
        do_pop();
        step(1'b1, 1'b1, 1'b0, 18'h00007, 1'b1);
        chk("repl_empty_count", 32'(count), 32'd1);
        chk("repl_empty_data", 32'(data_out), 32'h00007);
        chk("repl_empty_unf", 32'(underflow), 32'd1);
        do_pop();

        // Replace while full, then clear with coincident overflow.
        for (int i = 0; i < 4; i++) do_push(fill[i]);
        step(1'b1, 1'b1, 1'b0, 18'h0F0F0, 1'b1);
        chk("repl_full_data", 32'(data_out), 32'h0F0F0);
        chk("repl_full_count", 32'(count), 32'd4);
        step(1'b1, 1'b0, 1'b1, 18'h11111, 1'b1);
        chk("clr_vs_ovf", 32'(overflow), 32'd1);
        chk("clr_unf_only", 32'(underflow), 32'd0);
        do_pop();
        chk("after_repl_pop", 32'(data_out), 32'h04444);
        for (int i = 0; i < 3; i++) do_pop();

        // Error clear precedence.
        do_pop();
        chk("unf_again", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 1'b1, '0, 1'b1);
        chk("clr_unf", 32'(underflow), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        step(1'b0, 1'b1, 1'b1, '0, 1'b1);
        chk("clr_vs_unf", 32'(underflow), 32'd1);

        // Reset mid-operation with a pending push.
        do_push(18'h00AAA);
        do_push(18'h00BBB);
        do_push(18'h00CCC);
        step(1'b1, 1'b0, 1'b0, 18'h00DDD, 1'b0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_data", 32'(data_out), 32'd0);
        chk("midrst_flags", 32'({empty, full, almost_full, overflow, underflow}), 32'b10000);
        do_push(18'h0ABCD);
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_data", 32'(data_out), 32'h0ABCD);

        // Back-to-back push/pop churn.
        for (int i = 0; i < 12; i++) begin
            step(1'(i % 3 != 2), 1'(i % 2), 1'b0, WIDTH'(32'h100 + i), 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
